fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 The block SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 The block SHALL have port imem_addr  output  32  byte address of the requested instruction.
REQ-006 The block SHALL have port imem_rvalid  input  1  response strobe; one per accepted request.
REQ-007 The block SHALL have port imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-008 The block SHALL have port id_valid  output  1  head of fetch buffer valid to decode.
REQ-009 The block SHALL have port id_ready  input  1  decode accepts head this cycle.
REQ-010 The block SHALL have port id_instr  output  32  head instruction word.
REQ-011 The block SHALL have port id_pc  output  32  address of head instruction.
REQ-012 The block SHALL have port br_valid  input  1  one-cycle redirect strobe (branch taken, j, jal, jr).
REQ-013 The block SHALL have port br_target  input  32  redirect address, valid with br_valid.

Function
REQ-014 The block SHALL hold fetch PC, a 2-entry FIFO of {pc, instr}, and FSM states FETCH, WAIT, DRAIN.
REQ-015 The block SHALL keep at most one request outstanding; imem_addr SHALL equal fetch PC and stay stable while imem_req is high.
REQ-016 In FETCH, imem_req SHALL be 1 only when FIFO count plus outstanding is below 2; an issued request SHALL move to WAIT and advance PC by 4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
REQ-017 imem_req SHALL be a single-cycle pulse; imem_rvalid SHALL be accepted no earlier than the cycle after the request.
REQ-018 In WAIT, imem_rvalid SHALL push {request address, imem_rdata} into the FIFO and return to FETCH in the same cycle.
REQ-019 id_valid SHALL be 1 whenever FIFO count is non-zero; id_instr/id_pc SHALL show the head entry combinationally from registers.
REQ-020 The head SHALL pop when id_valid and id_ready are both 1; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 On br_valid, the FIFO SHALL be emptied, fetch PC set to br_target, and any same-cycle pop or push discarded.
REQ-022 On br_valid while in WAIT without imem_rvalid in that cycle, the FSM SHALL enter DRAIN; in DRAIN the next imem_rvalid SHALL be discarded and the FSM SHALL return to FETCH.
REQ-023 On br_valid coincident with imem_rvalid, the response SHALL be discarded and the FSM SHALL go to FETCH.
REQ-024 br_valid during DRAIN SHALL update fetch PC only; DRAIN SHALL persist until the pending response arrives.
REQ-025 Latency SHALL be: request in cycle N, response in cycle M>N, id_valid high in cycle M+1.
REQ-026 A full FIFO SHALL block new requests; an empty FIFO SHALL hold id_valid at 0.

Reset
REQ-027 While reset is 0: fetch PC = RESET_PC, FIFO count = 0, FSM = FETCH, imem_req = 0, id_valid = 0, id_instr = 0, id_pc = 0.
REQ-028 Assertion of reset mid-request SHALL abandon the outstanding request without waiting for imem_rvalid.
REQ-029 The first request SHALL issue in the first clock edge after reset returns to 1, with imem_addr = RESET_PC.

Configuration
REQ-030 With FETCH_CNT_EN defined, the block SHALL add output fetch_cnt (32) counting accepted pops (wrapping at 2^32) and output flush_cnt (32) counting br_valid strobes; both reset to 0.
REQ-031 Without FETCH_CNT_EN, both ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Release reset, memory answers 1 cycle after each request, id_ready=1 -> imem_addr 0x3000, 0x3004, 0x3008 in order; id_pc matches with id_valid one cycle after each response.
REQ-033 id_ready=0 for 6 cycles -> exactly 2 requests issued (0x3000, 0x3004), FIFO full, imem_req stays 0 until a pop.
REQ-034 br_valid with br_target=0x3100 while a request is outstanding, response 3 cycles later -> that response dropped, next request addr 0x3100, no stale id_pc presented.
REQ-035 br_valid coincident with imem_rvalid and id_ready -> FIFO empty next cycle, response dropped, next imem_addr = br_target.
REQ-036 Assert reset during WAIT, deassert -> outputs at reset values, next imem_addr = 0x3000, late imem_rvalid ignored.
REQ-037 With FETCH_CNT_EN, 5 pops and 2 redirects -> fetch_cnt = 5, flush_cnt = 2.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch with one outstanding request and 2-entry buffer.
// Define FETCH_CNT_EN to add the fetch_cnt / flush_cnt event counters.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        br_valid,
   input  logic [31:0] br_target
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      DRAIN
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic [31:0] fifo_pc  [2];
   logic [31:0] fifo_ins [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;

   assign push      = (state == WAIT) && imem_rvalid && !br_valid;
   assign pop       = id_valid && id_ready && !br_valid;
   assign id_valid  = (count != 2'd0);
   assign id_pc     = fifo_pc[rd_ptr];
   assign id_instr  = fifo_ins[rd_ptr];
   assign imem_addr = pc;

   // Next state and request pulse; a request issued under a redirect must be drained.
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      unique case (state)
         FETCH: begin
            if (reset && count != 2'd2) begin
               imem_req  = 1'b1;
               state_nxt = br_valid ? DRAIN : WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid)
               state_nxt = FETCH;
            else if (br_valid)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (imem_rvalid)
               state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // State register, fetch PC and address of the request in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         req_pc <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (br_valid)
            pc <= br_target;
         else if (imem_req)
            pc <= pc + 32'd4;
         if (imem_req)
            req_pc <= pc;
      end
   end

   // Two-entry fetch buffer; a redirect empties it and drops any push or pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count       <= 2'd0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fifo_pc[0]  <= '0;
         fifo_pc[1]  <= '0;
         fifo_ins[0] <= '0;
         fifo_ins[1] <= '0;
      end else if (br_valid) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            fifo_pc[wr_ptr]  <= req_pc;
            fifo_ins[wr_ptr] <= imem_rdata;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

`ifdef FETCH_CNT_EN
   // Event counters: instructions handed to decode and redirects seen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pop)
            fetch_cnt <= fetch_cnt + 32'd1;
         if (br_valid)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: memory responder plus scoreboard of the expected decode stream.
// Expected stream: sequential PCs from reset or from each redirect target.
module tb_fetch_ctrl;

   localparam logic [31:0] RPC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = '0;
`ifdef FETCH_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;
`endif

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        sb [$];
   logic [31:0] next_fill;
   logic [31:0] exp_fetch;
   logic        prev_br = 1'b0;
   logic        prev_rv = 1'b0;
   logic        prev_idv = 1'b0;
   int          pops = 0;
   int          flushes = 0;

   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          wcnt = 0;
   int          lat = 1;
   logic [31:0] req_log [$];

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RPC)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .br_valid    (br_valid),
      .br_target   (br_target)
`ifdef FETCH_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic sb_top();
      while (sb.size() < 8) begin
         sb.push_back({next_fill, mem_word(next_fill)});
         next_fill = next_fill + 32'd4;
      end
   endtask

   task automatic sb_restart(input logic [31:0] a);
      sb.delete();
      next_fill = a;
      sb_top();
   endtask

   // Monitor: compares every decode handshake and request against the model.
   always @(negedge clk) begin
      ent_t e;
      if (!reset) begin
         sb_restart(RPC);
         exp_fetch = RPC;
         prev_br   = 1'b0;
         prev_rv   = 1'b0;
         prev_idv  = 1'b0;
         pops      = 0;
         flushes   = 0;
      end else begin
         if (prev_br)
            check("flush_empty", 32'(id_valid), 32'd0);
         if (id_valid && !prev_idv && !prev_br)
            check("fill_latency", 32'(prev_rv), 32'd1);
         if (imem_req) begin
            check("req_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (br_valid) begin
            flushes++;
            sb_restart(br_target);
            exp_fetch = br_target;
         end else if (id_valid && id_ready) begin
            pops++;
            e = sb.pop_front();
            sb_top();
            check("id_pc", id_pc, e.pc);
            check("id_instr", id_instr, e.ins);
         end
         prev_br  = br_valid;
         prev_rv  = imem_rvalid;
         prev_idv = id_valid;
      end
   end

   // One cycle of stimulus; brm: 0 none, 1 redirect, 2 redirect only with a response.
   task automatic step(input bit rdy, input int brm, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
         if (wcnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
         end else begin
            wcnt--;
         end
      end
      if (imem_req) begin
         check("one_outstanding", 32'(pend), 32'd0);
         pend      = 1'b1;
         pend_addr = imem_addr;
         wcnt      = lat - 1;
         req_log.push_back(imem_addr);
      end
      id_ready  = rdy;
      br_valid  = (brm == 1) || (brm == 2 && imem_rvalid);
      br_target = tgt;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset       = 1'b0;
      br_valid    = 1'b0;
      id_ready    = 1'b0;
      imem_rvalid = 1'b0;
      pend        = 1'b0;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_instr", id_instr, 32'd0);
      check("rst_id_pc", id_pc, 32'd0);
      reset = 1'b1;
      #1;
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, RPC);
      req_log.delete();
      if (imem_req) begin
         pend      = 1'b1;
         pend_addr = imem_addr;
         wcnt      = lat - 1;
         req_log.push_back(imem_addr);
      end
   endtask

   initial begin
      logic [31:0] t;
      int          r;
      bit          rdy;
      int          brm;

      lat = 1;
      do_reset();
      repeat (12) step(1'b1, 0, '0);
      check("seq_req0", req_log[0], 32'h3000);
      check("seq_req1", req_log[1], 32'h3004);
      check("seq_req2", req_log[2], 32'h3008);

      do_reset();
      repeat (6) step(1'b0, 0, '0);
      check("full_req_count", 32'(req_log.size()), 32'd2);
      check("full_req1", req_log[1], 32'h3004);
      repeat (3) step(1'b0, 0, '0);
      check("full_hold", 32'(req_log.size()), 32'd2);
      step(1'b1, 0, '0);
      step(1'b0, 0, '0);
      check("pop_unblocks", 32'(req_log.size()), 32'd3);
      check("pop_req_addr", req_log[2], 32'h3008);

      lat = 3;
      do_reset();
      step(1'b1, 1, 32'h3100);
      lat = 1;
      repeat (8) step(1'b1, 0, '0);
      check("drain_req", req_log[1], 32'h3100);

      lat = 1;
      do_reset();
      step(1'b0, 0, '0);
      step(1'b0, 0, '0);
      step(1'b1, 2, 32'h4000);
      repeat (3) step(1'b1, 0, '0);
      check("coinc_req", req_log[2], 32'h4000);

      lat = 3;
      do_reset();
      step(1'b1, 0, '0);
      do_reset();
      check("rst_wait_req", req_log[0], RPC);
      lat = 1;
      repeat (10) step(1'b1, 0, '0);

      step(1'b1, 1, 32'hFFFF_FFF8);
      repeat (14) step(1'b1, 0, '0);

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         lat = $urandom_range(1, 4);
         r   = $urandom_range(0, 99);
         brm = (r < 4) ? 1 : ((r < 8) ? 2 : 0);
         rdy = ($urandom_range(0, 3) != 0);
         t   = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF4
                                           : ($urandom & 32'hFFFF_FFFC);
         step(rdy, brm, t);
      end
      step(1'b0, 0, '0);
`ifdef FETCH_CNT_EN
      check("fetch_cnt", fetch_cnt, 32'(pops));
      check("flush_cnt", flush_cnt, 32'(flushes));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
